// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between the
// instruction-fetch and data requesters, with a response timeout that turns a hung memory into a bus error.
module mem_arbiter #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_valid,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_ready,
   output logic            i_rvalid,
   output logic [XLEN-1:0] i_rdata,
   output logic            i_rerr,
   input  logic            d_valid,
   input  logic [XLEN-1:0] d_addr,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [XLEN-1:0] d_wmask,
   output logic            d_ready,
   output logic            d_rvalid,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_rerr,
   output logic            m_valid,
   output logic [XLEN-1:0] m_addr,
   output logic            m_we,
   output logic [XLEN-1:0] m_wdata,
   output logic [XLEN-1:0] m_wmask,
   input  logic            m_ready,
   input  logic            m_rvalid,
   input  logic [XLEN-1:0] m_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W:0] TO_LIM  = (CNT_W+1)'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_r;
   state_t            state_nxt_s;
   logic              owner_r;
   logic              last_grant_r;
   logic [XLEN-1:0]   addr_r;
   logic              we_r;
   logic [XLEN-1:0]   wdata_r;
   logic [XLEN-1:0]   wmask_r;
   logic [CNT_W-1:0]  cnt_r;

   logic              grant_i_s;
   logic              grant_d_s;
   logic              grant_s;
   logic              busy_s;
   logic              done_s;
   logic              timeout_s;
   logic [CNT_W:0]    elapsed_s;

   // Round-robin grant decision, only possible while idle and out of reset.
   always_comb begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if ((state_r == ST_IDLE) && !reset) begin
         if (i_valid && d_valid) begin
            grant_i_s = last_grant_r;
            grant_d_s = ~last_grant_r;
         end else begin
            grant_i_s = i_valid;
            grant_d_s = d_valid;
         end
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   assign grant_s = grant_i_s | grant_d_s;
   assign busy_s  = (state_r == ST_ISSUE) || (state_r == ST_RESP);
   assign done_s  = (state_r == ST_RESP) && m_rvalid;

   // Expiry is decided one cycle early so the registered error response
   // appears exactly TIMEOUT_CYCLES after the grant.
   always_comb begin
      elapsed_s = {1'b0, cnt_r} + (CNT_W+1)'(2);
      timeout_s = 1'b0;
      if (TO_EN && busy_s) begin
         timeout_s = (elapsed_s >= TO_LIM);
      end else begin
         timeout_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; completion takes priority over a same-cycle expiry.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else if (m_ready) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_RESP: begin
            if (done_s || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output logic: accept pulses and memory request valid.
   always_comb begin
      i_ready = grant_i_s;
      d_ready = grant_d_s;
      m_valid = 1'b0;
      case (state_r)
         ST_ISSUE: m_valid = 1'b1;
         default:  m_valid = 1'b0;
      endcase
   end

   assign m_addr  = addr_r;
   assign m_we    = we_r;
   assign m_wdata = wdata_r;
   assign m_wmask = wmask_r;

   // Request latch, ownership, round-robin history and saturating timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_r      <= 1'b0;
         last_grant_r <= 1'b1;
         addr_r       <= {XLEN{1'b0}};
         we_r         <= 1'b0;
         wdata_r      <= {XLEN{1'b0}};
         wmask_r      <= {XLEN{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
      end else if (grant_s) begin
         owner_r      <= grant_d_s;
         last_grant_r <= grant_d_s;
         cnt_r        <= {CNT_W{1'b0}};
         if (grant_d_s) begin
            addr_r  <= d_addr;
            we_r    <= d_we;
            wdata_r <= d_wdata;
            wmask_r <= d_wmask;
         end else begin
            addr_r  <= i_addr;
            we_r    <= 1'b0;
            wdata_r <= {XLEN{1'b0}};
            wmask_r <= {XLEN{1'b0}};
         end
      end else if (busy_s) begin
         if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Registered responses routed to the owner only; responses outside RESP are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_rvalid <= 1'b0;
         i_rdata  <= {XLEN{1'b0}};
         i_rerr   <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= {XLEN{1'b0}};
         d_rerr   <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         i_rerr   <= 1'b0;
         d_rvalid <= 1'b0;
         d_rerr   <= 1'b0;
         if (done_s) begin
            if (owner_r) begin
               d_rvalid <= 1'b1;
               d_rdata  <= m_rdata;
            end else begin
               i_rvalid <= 1'b1;
               i_rdata  <= m_rdata;
            end
         end else if (timeout_s) begin
            if (owner_r) begin
               d_rvalid <= 1'b1;
               d_rerr   <= 1'b1;
               d_rdata  <= {XLEN{1'b0}};
            end else begin
               i_rvalid <= 1'b1;
               i_rerr   <= 1'b1;
               i_rdata  <= {XLEN{1'b0}};
            end
         end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified, variable-latency memory port between two requesters: the instruction-fetch side and the data load/store side of the core.
- Arbitration is round-robin, with one outstanding transaction at a time.
- A response timeout converts a hung memory into a bus error returned to the owning requester.
- Sits between the core and the single external memory once separate instruction and data memories are merged.

Parameters:
XLEN, 32, address/data width
TIMEOUT_CYCLES, 255, max cycles from grant to m_rvalid before error; 0 disables timeout
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_valid  in  1  fetch request
i_addr  in  XLEN  fetch address
i_ready  out  1  fetch request accepted (1-cycle pulse)
i_rvalid  out  1  fetch response valid (1-cycle pulse)
i_rdata  out  XLEN  fetch read data
i_rerr  out  1  fetch response is timeout error
d_valid  in  1  data request
d_addr  in  XLEN  data address
d_we  in  1  1=store, 0=load
d_wdata  in  XLEN  store data
d_wmask  in  XLEN  store bit mask
d_ready  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data response valid (1-cycle pulse)
d_rdata  out  XLEN  load data
d_rerr  out  1  data response is timeout error
m_valid  out  1  memory request valid
m_addr  out  XLEN  memory address
m_we  out  1  memory write enable
m_wdata  out  XLEN  memory write data
m_wmask  out  XLEN  memory write mask
m_ready  in  1  memory accepts request
m_rvalid  in  1  memory response; issued for reads and writes
m_rdata  in  XLEN  memory read data

Behaviour:
- FSM states are IDLE, ISSUE and RESP. Registers: state, owner (0=I, 1=D), last_grant, latched addr/we/wdata/wmask, timeout counter.
- Reset values: state=IDLE, last_grant=D so I wins the first contention, counter=0. All outputs 0: m_valid, m_*, *_ready, *_rvalid, *_rerr, *_rdata.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - On grant: pulse that requester's *_ready in the same cycle, latch its fields (fetch forces we=0, wdata=0, wmask=0), set owner and last_grant, clear the counter, go to ISSUE.
  - With no request, stay in IDLE.
- Requester rule: hold *_valid and fields stable until *_ready. After *_ready the requester may drop valid or present the next request; it is not accepted before the current response.
- ISSUE:
  - m_valid=1 with the latched fields, held stable until m_ready.
  - On m_valid & m_ready, go to RESP.
- RESP:
  - On m_rvalid: pulse owner's *_rvalid for one cycle with *_rdata=m_rdata (registered, 1 cycle after m_rvalid), *_rerr=0, go to IDLE.
  - A store also gets a *_rvalid (completion ack); its rdata is don't-care.
- Timeout:
  - Counter increments each cycle in ISSUE and RESP.
  - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES without completion: drop m_valid, pulse owner's *_rvalid with *_rerr=1 and *_rdata=0, go to IDLE.
  - Completion on the same cycle as expiry wins, with no error.
- m_rvalid in IDLE or ISSUE is ignored; this covers stale responses after a timeout or reset.
- The non-owner's *_rvalid is never asserted. *_ready and *_rvalid are never asserted for both requesters in one cycle.
- Minimum timing (m_ready immediate, m_rvalid 1 cycle after acceptance): ready at N, m_valid at N+1, m_rvalid at N+2, *_rvalid at N+3, next grant at N+3.
- Reset mid-transaction: the next cycle is IDLE with m_valid=0; no response is delivered for the aborted transaction.
- Width: counter saturates at the top of CNT_W; it never wraps.

Test Plan:
- Single fetch: i_valid, i_addr=0x100, memory m_ready=1 and m_rvalid next cycle with rdata=0xDEADBEEF -> i_ready at cycle 0, m_addr=0x100 with m_we=0 at cycle 1, i_rvalid=1 with i_rdata=0xDEADBEEF at cycle 3; d_* all 0.
- Contention round-robin: i_valid and d_valid held high for 4 transactions -> grant order I, D, I, D; no cycle has both *_ready high.
- Store: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_wmask=0xFF, m_ready delayed 3 cycles -> m_valid high with fields stable for 4 cycles, then d_rvalid=1 with d_rerr=0.
- Timeout: TIMEOUT_CYCLES=8, m_ready=1, m_rvalid never asserted -> d_rvalid=1 with d_rerr=1 and d_rdata=0 exactly 8 cycles after grant. A stray m_rvalid afterwards produces no *_rvalid.
- Reset mid-op: assert reset for 1 cycle while in RESP -> next cycle all outputs 0; a subsequent m_rvalid is ignored; a new fetch completes normally.
- Back-to-back: a requester with valid held continuously -> re-granted in the cycle of its *_rvalid, giving one transaction per 3 cycles with zero-wait memory.
